// File: rtl/audio_frame_streamer.sv
// Ping-pong buffers incoming audio frames and sends each full buffer to a UART
// transmitter as a packet of sync byte, sequence byte and truncated samples.
module audio_frame_streamer #(
  parameter int unsigned BITS      = 16,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned OUT_BYTES = 1,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     s_valid,
  input  logic [CHANNELS*BITS-1:0] s_data,
  output logic                     s_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [7:0]               buf_seq,
  output logic                     overrun,
  input  logic                     clear_overrun
);
  localparam int unsigned NB = DEPTH * CHANNELS * OUT_BYTES;
  localparam int unsigned AW = $clog2(NB);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FB = CHANNELS * OUT_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_SYNC,
    ST_HDR_SEQ,
    ST_PAYLOAD,
    ST_DONE
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [2][2**AW];
  logic            r_fill_sel;
  logic            r_full;
  logic [PW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_idx;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic [7:0]      r_buf_seq;
  logic            r_overrun;

  logic            w_busy;
  logic            w_accept;
  logic            w_swap;
  logic            w_wr_sel;
  logic            w_send_sel;
  logic            w_hs;
  logic [AW-1:0]   w_rd_addr;
  logic            w_unused_low;

  // Only the fill side can stall the source: full buffer while a packet is in flight.
  assign w_busy     = (r_state != ST_IDLE);
  assign s_ready    = !(r_full && w_busy);
  assign w_accept   = s_valid && s_ready;
  assign w_swap     = r_full && !w_busy;
  assign w_wr_sel   = r_full ? ~r_fill_sel : r_fill_sel;
  assign w_send_sel = ~r_fill_sel;
  assign w_hs       = r_tx_valid && tx_ready;
  assign w_rd_addr  = (r_state == ST_HDR_SEQ) ? AW'(0) : r_rd_idx + AW'(1);

  // Sample bits below the transmitted bytes are dropped by design.
  assign w_unused_low = ^s_data;

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign buf_seq  = r_buf_seq;
  assign overrun  = r_overrun;

  // Frame write: top OUT_BYTES of each channel, MSB byte at the lower address.
  always_ff @(posedge clk) begin
    if (n_reset && w_accept) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned b = 0; b < OUT_BYTES; b++) begin
          r_mem[w_wr_sel][AW'(32'(r_wr_ptr) * FB + c * OUT_BYTES + b)] <=
            s_data[c*BITS + BITS - 1 - 8*b -: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state    <= ST_IDLE;
      r_fill_sel <= 1'b0;
      r_full     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_idx   <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_buf_seq  <= 8'h00;
      r_overrun  <= 1'b0;
    end else begin
      if (s_valid && !s_ready) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end

      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      // A swap always leaves wr_ptr at 0, so it never coincides with the last write.
      if (w_accept && (r_wr_ptr == PW'(DEPTH - 1))) begin
        r_full <= 1'b1;
      end else if (w_swap) begin
        r_full <= 1'b0;
      end
      if (w_swap) begin
        r_fill_sel <= ~r_fill_sel;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_swap) begin
            r_state    <= ST_HDR_SYNC;
            r_tx_valid <= 1'b1;
            r_tx_data  <= SYNC;
          end
        end
        ST_HDR_SYNC: begin
          if (w_hs) begin
            r_state   <= ST_HDR_SEQ;
            r_tx_data <= r_buf_seq;
          end
        end
        ST_HDR_SEQ: begin
          if (w_hs) begin
            r_state   <= ST_PAYLOAD;
            r_tx_data <= r_mem[w_send_sel][w_rd_addr];
            r_rd_idx  <= w_rd_addr;
          end
        end
        ST_PAYLOAD: begin
          if (w_hs) begin
            if (r_rd_idx == AW'(NB - 1)) begin
              r_state    <= ST_DONE;
              r_tx_valid <= 1'b0;
            end else begin
              r_tx_data <= r_mem[w_send_sel][w_rd_addr];
              r_rd_idx  <= w_rd_addr;
            end
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_buf_seq <= r_buf_seq + 8'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_frame_streamer.sv
// Directed bench for audio_frame_streamer: one-byte and two-byte sample variants
// driven from shared stimulus, outputs checked against hand-computed bytes.
module tb_audio_frame_streamer;
  logic        clk;
  logic        n_reset;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  buf_seq;
  logic        overrun;
  logic        clear_overrun;
  logic        s_ready2;
  logic [7:0]  tx_data2;
  logic        tx_valid2;
  logic [7:0]  buf_seq2;
  logic        overrun2;

  int checks = 0;
  int errors = 0;

  audio_frame_streamer #(
    .BITS(16), .CHANNELS(2), .DEPTH(4), .OUT_BYTES(1), .SYNC(8'hA5)
  ) u_dut (
    .clk(clk), .n_reset(n_reset), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .buf_seq(buf_seq), .overrun(overrun),
    .clear_overrun(clear_overrun)
  );

  audio_frame_streamer #(
    .BITS(16), .CHANNELS(2), .DEPTH(4), .OUT_BYTES(2), .SYNC(8'hA5)
  ) u_dut2 (
    .clk(clk), .n_reset(n_reset), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready), .buf_seq(buf_seq2), .overrun(overrun2),
    .clear_overrun(clear_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_v(input int which);
    return (which == 0) ? tx_valid : tx_valid2;
  endfunction

  function automatic logic [7:0] get_d(input int which);
    return (which == 0) ? tx_data : tx_data2;
  endfunction

  // Wait (bounded) for a presented byte, check it, let the next edge take it.
  task automatic expect_byte(input int which, input string tag, input logic [7:0] exp);
    int n = 0;
    while (get_v(which) !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {23'd0, get_v(which), get_d(which)}, {23'd0, 1'b1, exp});
    @(negedge clk);
  endtask

  task automatic send4(input logic [7:0] b0, input logic [7:0] lo0,
                       input logic [7:0] b1, input logic [7:0] lo1, input int step);
    for (int i = 0; i < 4; i++) begin
      s_data  = {8'(int'(b1) + step * i), lo1, 8'(int'(b0) + step * i), lo0};
      s_valid = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    n_reset       = 1'b0;
    s_valid       = 1'b0;
    clear_overrun = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  initial begin
    n_reset       = 1'b0;
    s_valid       = 1'b0;
    s_data        = '0;
    tx_ready      = 1'b0;
    clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_buf_seq", 32'(buf_seq), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Basic packet, constant frames
    tx_ready = 1'b1;
    send4(8'h12, 8'h34, 8'hAB, 8'hCD, 0);
    chk("t1_valid_before_swap", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_after_swap", {23'd0, tx_valid, tx_data}, 32'h1A5);
    expect_byte(0, "t1_sync", 8'hA5);
    expect_byte(0, "t1_seq", 8'h00);
    for (int i = 0; i < 4; i++) begin
      expect_byte(0, $sformatf("t1_f%0d_c0", i), 8'h12);
      expect_byte(0, $sformatf("t1_f%0d_c1", i), 8'hAB);
    end
    chk("t1_done_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("t1_buf_seq", 32'(buf_seq), 32'd1);

    // Stall mid-payload for 10 cycles
    send4(8'h10, 8'h00, 8'h20, 8'hFF, 1);
    expect_byte(0, "t2_sync", 8'hA5);
    expect_byte(0, "t2_seq", 8'h01);
    expect_byte(0, "t2_f0_c0", 8'h10);
    expect_byte(0, "t2_f0_c1", 8'h20);
    tx_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t2_stall%0d", k), {23'd0, tx_valid, tx_data}, 32'h111);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      expect_byte(0, $sformatf("t2_f%0d_c0", i), 8'(8'h10 + i));
      expect_byte(0, $sformatf("t2_f%0d_c1", i), 8'(8'h20 + i));
    end
    @(negedge clk);
    chk("t2_buf_seq", 32'(buf_seq), 32'd2);

    // Back-pressure and overrun with transmitter stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_data  = {8'(8'h40 + i), 8'h00, 8'(8'h30 + i), 8'h00};
      s_valid = 1'b1;
      chk($sformatf("t3_s_ready%0d", i), 32'(s_ready), (i < 8) ? 32'd1 : 32'd0);
      if (i == 8) chk("t3_ovr_before", 32'(overrun), 32'd0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("t3_ovr_set", 32'(overrun), 32'd1);
    @(negedge clk);
    chk("t3_ovr_sticky", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("t3_ovr_clear", 32'(overrun), 32'd0);
    s_valid       = 1'b1;
    clear_overrun = 1'b1;
    @(negedge clk);
    s_valid       = 1'b0;
    clear_overrun = 1'b0;
    chk("t3_ovr_set_wins", 32'(overrun), 32'd1);
    chk("t3_s_ready_held", 32'(s_ready), 32'd0);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("t3_ovr_clear2", 32'(overrun), 32'd0);
    tx_ready = 1'b1;
    expect_byte(0, "t3a_sync", 8'hA5);
    expect_byte(0, "t3a_seq", 8'h02);
    for (int i = 0; i < 4; i++) begin
      expect_byte(0, $sformatf("t3a_f%0d_c0", i), 8'(8'h30 + i));
      expect_byte(0, $sformatf("t3a_f%0d_c1", i), 8'(8'h40 + i));
    end
    expect_byte(0, "t3b_sync", 8'hA5);
    expect_byte(0, "t3b_seq", 8'h03);
    for (int i = 4; i < 8; i++) begin
      expect_byte(0, $sformatf("t3b_f%0d_c0", i), 8'(8'h30 + i));
      expect_byte(0, $sformatf("t3b_f%0d_c1", i), 8'(8'h40 + i));
    end
    @(negedge clk);
    chk("t3_buf_seq", 32'(buf_seq), 32'd4);

    // Reset in the middle of the payload
    send4(8'h12, 8'h34, 8'hAB, 8'hCD, 0);
    expect_byte(0, "t4_sync", 8'hA5);
    expect_byte(0, "t4_seq", 8'h04);
    expect_byte(0, "t4_f0_c0", 8'h12);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    chk("t4_rst_valid", 32'(tx_valid), 32'd0);
    chk("t4_rst_data", 32'(tx_data), 32'd0);
    chk("t4_rst_seq", 32'(buf_seq), 32'd0);
    chk("t4_rst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    chk("t4_no_more", 32'(tx_valid), 32'd0);
    send4(8'h55, 8'h00, 8'h66, 8'h00, 0);
    expect_byte(0, "t4n_sync", 8'hA5);
    expect_byte(0, "t4n_seq", 8'h00);
    for (int i = 0; i < 4; i++) begin
      expect_byte(0, $sformatf("t4n_f%0d_c0", i), 8'h55);
      expect_byte(0, $sformatf("t4n_f%0d_c1", i), 8'h66);
    end

    // Two bytes per sample on the second instance
    do_reset();
    send4(8'h80, 8'h01, 8'h7F, 8'hFE, 0);
    expect_byte(1, "t5_sync", 8'hA5);
    expect_byte(1, "t5_seq", 8'h00);
    for (int i = 0; i < 4; i++) begin
      expect_byte(1, $sformatf("t5_f%0d_b0", i), 8'h80);
      expect_byte(1, $sformatf("t5_f%0d_b1", i), 8'h01);
      expect_byte(1, $sformatf("t5_f%0d_b2", i), 8'h7F);
      expect_byte(1, $sformatf("t5_f%0d_b3", i), 8'hFE);
    end
    @(negedge clk);
    chk("t5_buf_seq", 32'(buf_seq2), 32'd1);

    // Sequence number wraps after 256 packets
    do_reset();
    for (int p = 0; p < 257; p++) begin
      send4(8'h12, 8'h34, 8'hAB, 8'hCD, 0);
      expect_byte(0, $sformatf("t6_p%0d_sync", p), 8'hA5);
      expect_byte(0, $sformatf("t6_p%0d_seq", p), 8'(p));
      for (int i = 0; i < 4; i++) begin
        expect_byte(0, $sformatf("t6_p%0d_f%0d_c0", p, i), 8'h12);
        expect_byte(0, $sformatf("t6_p%0d_f%0d_c1", p, i), 8'hAB);
      end
    end
    @(negedge clk);
    chk("t6_buf_seq", 32'(buf_seq), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
